mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Owns the select line of a 2:1 data mux and shares one output channel between two
//  valid/ready requesters. Uses round-robin arbitration with a bounded burst length.
//  Data passes through the mux with zero latency; only the select is registered, via the FSM.
//  Sits in front of any single-consumer sink that two producers must share.
// PARAMETERS
//  DW         8   data width of in0_data/in1_data/out_data
//  MAX_BURST  4   max consecutive accepted beats per grant (>=1); counter width = $clog2(MAX_BURST+1)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in0_valid  in   1   requester 0 has a beat
//  in0_data   in   DW  requester 0 data
//  in0_ready  out  1   requester 0 beat accepted this cycle when in0_valid & in0_ready
//  in1_valid  in   1   requester 1 has a beat
//  in1_data   in   DW  requester 1 data
//  in1_ready  out  1   requester 1 beat accepted when in1_valid & in1_ready
//  out_valid  out  1   output beat present
//  out_data   out  DW  muxed data: out_sel ? in1_data : in0_data, forced 0 when out_valid=0
//  out_ready  in   1   sink accepts beat
//  out_sel    out  1   mux select = current/last owner (0 or 1)
//  busy       out  1   1 in OWN0/OWN1, 0 in IDLE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, last_winner=1 (req0 first priority), beat_cnt=0,
//   out_sel=0; hence out_valid=0, out_data=0, in0_ready=in1_ready=0, busy=0.
//  FSM states: IDLE, OWN0, OWN1.
//  IDLE: out_valid=0, both readys=0. At the edge:
//   - only in0_valid      -> OWN0
//   - only in1_valid      -> OWN1
//   - both valid          -> OWN of the requester that is NOT last_winner
//   - neither             -> stay IDLE
//   On entry to OWNk: out_sel<=k, last_winner<=k, beat_cnt<=0.
//   Arbitration latency: one cycle from first valid to out_valid.
//  OWNk (combinational): out_valid=ink_valid; ink_ready=out_ready; other ready=0.
//   Transfer = ink_valid & out_ready.
//  OWNk transitions at edge, in priority order:
//   - transfer and beat_cnt==MAX_BURST-1 -> IDLE (burst limit; beat_cnt<=0)
//   - ink_valid==0 -> IDLE (owner released)
//   - transfer -> stay, beat_cnt+1
//   - stall (valid & !out_ready) -> stay; beat_cnt, out_sel and out_data all hold
//  Burst limit applies even when the other requester is idle:
//   - a lone requester sees one bubble cycle every MAX_BURST beats.
//  With both streaming and out_ready=1: MAX_BURST beats from 0, 1 bubble,
//   MAX_BURST beats from 1, 1 bubble, repeating.
//  out_sel keeps the last owner in IDLE; it changes only on IDLE->OWNk.
//  A requester must hold valid/data stable until accepted. Dropping valid while
//   owning is a release, not an error.
//  The non-owner's valid has no effect until IDLE. It is never acked while not owner.
//  Reset mid-burst: the next cycle is the reset state. Any un-accepted beat is not
//   transferred, and priority returns to requester 0.
//  No data is stored in this block; no beat is duplicated or dropped.
// TESTING (DW=8, MAX_BURST=4)
//  1. rst=1 for 2 cycles, any inputs -> out_valid=0, out_data=0, readys=0, out_sel=0, busy=0.
//  2. in0_valid=1 in0_data=8'hA5, out_ready=1 from cycle 0 -> cycle 1: out_sel=0, out_valid=1,
//     out_data=8'hA5, in0_ready=1; in1_ready stays 0.
//  3. Both valid from reset release, out_ready=1 -> cycles 1-4 owner 0, cycle 5 idle,
//     cycles 6-9 owner 1, cycle 10 idle, cycles 11-14 owner 0.
//  4. Owner 1 streaming (in1_data=8'h3C), out_ready=0 for 3 cycles -> out_valid=1,
//     out_data=8'h3C stable, in1_ready=0, beat_cnt frozen; burst completes after out_ready=1.
//  5. Owner 0 drops in0_valid after 2 beats while in1_valid=1 -> next cycle IDLE,
//     then OWN1; out_sel 0->1 exactly on IDLE->OWN1.
//  6. rst=1 for 1 cycle after 2 beats of owner 1, both valid after -> IDLE, then OWN0 wins.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select of a 2:1 data mux.
// Only the select is registered; data passes from the owning requester to the sink with zero latency.
module mux2_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_sel,
    output logic          busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_winner;
    logic          last_winner_next;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_next;
    logic          sel;
    logic          sel_next;
    logic          owner_valid;
    logic          transfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            beat_cnt    <= '0;
            sel         <= 1'b0;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
            beat_cnt    <= beat_cnt_next;
            sel         <= sel_next;
        end
    end

    always_comb begin
        state_next       = state;
        last_winner_next = last_winner;
        beat_cnt_next    = beat_cnt;
        sel_next         = sel;
        owner_valid      = 1'b0;
        in0_ready        = 1'b0;
        in1_ready        = 1'b0;

        case (state)
            IDLE: begin
                // Requester 0 wins unless requester 1 also asks and 0 won last time.
                if (in0_valid && (!in1_valid || last_winner)) begin
                    state_next       = OWN0;
                    sel_next         = 1'b0;
                    last_winner_next = 1'b0;
                    beat_cnt_next    = '0;
                end else if (in1_valid) begin
                    state_next       = OWN1;
                    sel_next         = 1'b1;
                    last_winner_next = 1'b1;
                    beat_cnt_next    = '0;
                end
            end
            OWN0: begin
                owner_valid = in0_valid;
                in0_ready   = out_ready;
            end
            OWN1: begin
                owner_valid = in1_valid;
                in1_ready   = out_ready;
            end
            default: state_next = IDLE;
        endcase

        transfer = owner_valid && out_ready;

        // Burst limit takes precedence over release; a stall holds everything.
        if (state != IDLE) begin
            if (transfer && (beat_cnt == LAST_BEAT)) begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end else if (!owner_valid) begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end else if (transfer) begin
                beat_cnt_next = beat_cnt + CW'(1);
            end
        end
    end

    assign out_valid = owner_valid;
    assign out_data  = owner_valid ? (sel ? in1_data : in0_data) : '0;
    assign out_sel   = sel;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scenario bench for mux2_rr_arbiter: per-cycle ownership timeline checks plus an ordered beat scoreboard.
module tb_mux2_rr_arbiter;

    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          clk;
    logic          rst;
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_sel;
    logic          busy;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] d0[$];
    logic [DW-1:0] d1[$];
    int            vectors     = 0;
    int            miscompares = 0;

    mux2_rr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill_data();
        d0.delete();
        d1.delete();
        for (int i = 0; i < 16; i++) begin
            d0.push_back(DW'($urandom_range(0, 255)));
            d1.push_back(DW'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in0_data  = DW'($urandom_range(0, 255));
            in1_data  = DW'($urandom_range(0, 255));
            if (c > 0) begin
                @(negedge clk);
                vectors++;
                if ({out_valid, in0_ready, in1_ready, out_sel, busy} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL reset ctl c%0d got %b exp 00000", c, {out_valid, in0_ready, in1_ready, out_sel, busy});
                end
                vectors++;
                if (out_data !== '0) begin
                    miscompares++;
                    $display("FAIL reset data c%0d got %h exp 00", c, out_data);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Lone requester 0: first beat 8'hA5 one cycle after valid, bubble after every MAX_BURST beats.
    task automatic test_single();
        int est[32];
        int i0;
        int es;
        logic esel, ev;
        logic [DW-1:0] ed;
        logic [4:0] ctl_exp;
        logic [DW:0] want;
        apply_reset();
        fill_data();
        d0[0] = 8'hA5;
        for (int b = 0; b < 6; b++) exp_q.push_back({1'b0, d0[b]});
        for (int c = 0; c < 10; c++) est[c] = ((c >= 1 && c <= 4) || (c >= 6 && c <= 8)) ? 1 : 0;
        i0 = 0;
        esel = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in0_valid = (i0 < 6);
            in0_data  = in0_valid ? d0[i0] : '0;
            in1_valid = 1'b0;
            in1_data  = DW'($urandom_range(0, 255));
            @(negedge clk);
            es = est[c];
            ev = (es == 1 && in0_valid) || (es == 2 && in1_valid);
            if (es != 0) esel = (es == 2);
            ed = ev ? (esel ? in1_data : in0_data) : '0;
            ctl_exp = {ev, esel, (es == 1) && out_ready, (es == 2) && out_ready, es != 0};
            vectors++;
            if ({out_valid, out_sel, in0_ready, in1_ready, busy} !== ctl_exp) begin
                miscompares++;
                $display("FAIL single ctl c%0d got %b exp %b", c, {out_valid, out_sel, in0_ready, in1_ready, busy}, ctl_exp);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("FAIL single data c%0d got %h exp %h", c, out_data, ed);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL single beat c%0d got %h exp none", c, {out_sel, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_sel, out_data} !== want) begin
                        miscompares++;
                        $display("FAIL single beat c%0d got %h exp %h", c, {out_sel, out_data}, want);
                    end
                end
            end
            if (in0_valid && es == 1 && out_ready) i0++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single drain got %0d left exp 0", exp_q.size());
        end
    endtask

    // Both streaming with out_ready=1: MAX_BURST beats per owner, one bubble between, alternating.
    task automatic test_round_robin();
        int est[32];
        int i0, i1;
        int es;
        logic esel, ev;
        logic [DW-1:0] ed;
        logic [4:0] ctl_exp;
        logic [DW:0] want;
        apply_reset();
        fill_data();
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, d0[b]});
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, d1[b]});
        for (int b = 4; b < 8; b++) exp_q.push_back({1'b0, d0[b]});
        for (int b = 4; b < 8; b++) exp_q.push_back({1'b1, d1[b]});
        for (int c = 0; c < 22; c++) begin
            if (c >= 1 && c <= 19 && ((c - 1) % 5) != 4) est[c] = (((c - 1) / 5) % 2 == 0) ? 1 : 2;
            else est[c] = 0;
        end
        i0 = 0;
        i1 = 0;
        esel = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            in0_valid = (i0 < 8);
            in0_data  = in0_valid ? d0[i0] : '0;
            in1_valid = (i1 < 8);
            in1_data  = in1_valid ? d1[i1] : '0;
            @(negedge clk);
            es = est[c];
            ev = (es == 1 && in0_valid) || (es == 2 && in1_valid);
            if (es != 0) esel = (es == 2);
            ed = ev ? (esel ? in1_data : in0_data) : '0;
            ctl_exp = {ev, esel, (es == 1) && out_ready, (es == 2) && out_ready, es != 0};
            vectors++;
            if ({out_valid, out_sel, in0_ready, in1_ready, busy} !== ctl_exp) begin
                miscompares++;
                $display("FAIL rr ctl c%0d got %b exp %b", c, {out_valid, out_sel, in0_ready, in1_ready, busy}, ctl_exp);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("FAIL rr data c%0d got %h exp %h", c, out_data, ed);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr beat c%0d got %h exp none", c, {out_sel, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_sel, out_data} !== want) begin
                        miscompares++;
                        $display("FAIL rr beat c%0d got %h exp %h", c, {out_sel, out_data}, want);
                    end
                end
            end
            if (in0_valid && es == 1 && out_ready) i0++;
            if (in1_valid && es == 2 && out_ready) i1++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rr drain got %0d left exp 0", exp_q.size());
        end
    endtask

    // Owner 1 stalls on beat 8'h3C for 3 cycles mid-burst; the beat count must freeze.
    task automatic test_stall();
        int est[32];
        int i1;
        int es;
        logic esel, ev;
        logic [DW-1:0] ed;
        logic [4:0] ctl_exp;
        logic [DW:0] want;
        apply_reset();
        fill_data();
        d1[1] = 8'h3C;
        for (int b = 0; b < 5; b++) exp_q.push_back({1'b1, d1[b]});
        for (int c = 0; c < 12; c++) est[c] = ((c >= 1 && c <= 7) || (c >= 9 && c <= 10)) ? 2 : 0;
        i1 = 0;
        esel = 1'b0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in0_valid = 1'b0;
            in0_data  = DW'($urandom_range(0, 255));
            in1_valid = (i1 < 5);
            in1_data  = in1_valid ? d1[i1] : '0;
            @(negedge clk);
            es = est[c];
            ev = (es == 1 && in0_valid) || (es == 2 && in1_valid);
            if (es != 0) esel = (es == 2);
            ed = ev ? (esel ? in1_data : in0_data) : '0;
            ctl_exp = {ev, esel, (es == 1) && out_ready, (es == 2) && out_ready, es != 0};
            vectors++;
            if ({out_valid, out_sel, in0_ready, in1_ready, busy} !== ctl_exp) begin
                miscompares++;
                $display("FAIL stall ctl c%0d got %b exp %b", c, {out_valid, out_sel, in0_ready, in1_ready, busy}, ctl_exp);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("FAIL stall data c%0d got %h exp %h", c, out_data, ed);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall beat c%0d got %h exp none", c, {out_sel, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_sel, out_data} !== want) begin
                        miscompares++;
                        $display("FAIL stall beat c%0d got %h exp %h", c, {out_sel, out_data}, want);
                    end
                end
            end
            if (in1_valid && es == 2 && out_ready) i1++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall drain got %0d left exp 0", exp_q.size());
        end
    endtask

    // Owner 0 releases after 2 beats with requester 1 waiting; select flips only on IDLE->OWN1.
    task automatic test_release();
        int est[32];
        int i0, i1;
        int es;
        logic esel, ev;
        logic [DW-1:0] ed;
        logic [4:0] ctl_exp;
        logic [DW:0] want;
        apply_reset();
        fill_data();
        for (int b = 0; b < 2; b++) exp_q.push_back({1'b0, d0[b]});
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, d1[b]});
        for (int c = 0; c < 10; c++) est[c] = (c >= 1 && c <= 3) ? 1 : ((c >= 5 && c <= 8) ? 2 : 0);
        i0 = 0;
        i1 = 0;
        esel = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in0_valid = (i0 < 2);
            in0_data  = in0_valid ? d0[i0] : '0;
            in1_valid = (i1 < 4);
            in1_data  = in1_valid ? d1[i1] : '0;
            @(negedge clk);
            es = est[c];
            ev = (es == 1 && in0_valid) || (es == 2 && in1_valid);
            if (es != 0) esel = (es == 2);
            ed = ev ? (esel ? in1_data : in0_data) : '0;
            ctl_exp = {ev, esel, (es == 1) && out_ready, (es == 2) && out_ready, es != 0};
            vectors++;
            if ({out_valid, out_sel, in0_ready, in1_ready, busy} !== ctl_exp) begin
                miscompares++;
                $display("FAIL release ctl c%0d got %b exp %b", c, {out_valid, out_sel, in0_ready, in1_ready, busy}, ctl_exp);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("FAIL release data c%0d got %h exp %h", c, out_data, ed);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL release beat c%0d got %h exp none", c, {out_sel, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_sel, out_data} !== want) begin
                        miscompares++;
                        $display("FAIL release beat c%0d got %h exp %h", c, {out_sel, out_data}, want);
                    end
                end
            end
            if (in0_valid && es == 1 && out_ready) i0++;
            if (in1_valid && es == 2 && out_ready) i1++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL release drain got %0d left exp 0", exp_q.size());
        end
    endtask

    // Reset pulse after 2 beats of owner 1 with both valid afterwards: IDLE, then requester 0 wins.
    task automatic test_reset_mid_burst();
        int est[32];
        int i0, i1;
        int es;
        logic esel, ev;
        logic [DW-1:0] ed;
        logic [4:0] ctl_exp;
        logic [DW:0] want;
        apply_reset();
        fill_data();
        for (int b = 0; b < 2; b++) exp_q.push_back({1'b1, d1[b]});
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, d0[b]});
        for (int b = 2; b < 4; b++) exp_q.push_back({1'b1, d1[b]});
        for (int c = 0; c < 14; c++) begin
            if ((c >= 1 && c <= 3) || (c >= 10 && c <= 12)) est[c] = 2;
            else if (c >= 5 && c <= 8) est[c] = 1;
            else est[c] = 0;
        end
        i0 = 0;
        i1 = 0;
        esel = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rst       = (c == 3);
            out_ready = (c != 3);
            in0_valid = (c >= 3) && (i0 < 4);
            in0_data  = in0_valid ? d0[i0] : '0;
            in1_valid = (i1 < 4);
            in1_data  = in1_valid ? d1[i1] : '0;
            @(negedge clk);
            es = est[c];
            ev = (es == 1 && in0_valid) || (es == 2 && in1_valid);
            if (es != 0) esel = (es == 2);
            ed = ev ? (esel ? in1_data : in0_data) : '0;
            ctl_exp = {ev, esel, (es == 1) && out_ready, (es == 2) && out_ready, es != 0};
            vectors++;
            if ({out_valid, out_sel, in0_ready, in1_ready, busy} !== ctl_exp) begin
                miscompares++;
                $display("FAIL midrst ctl c%0d got %b exp %b", c, {out_valid, out_sel, in0_ready, in1_ready, busy}, ctl_exp);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("FAIL midrst data c%0d got %h exp %h", c, out_data, ed);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL midrst beat c%0d got %h exp none", c, {out_sel, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_sel, out_data} !== want) begin
                        miscompares++;
                        $display("FAIL midrst beat c%0d got %h exp %h", c, {out_sel, out_data}, want);
                    end
                end
            end
            if (in0_valid && es == 1 && out_ready) i0++;
            if (in1_valid && es == 2 && out_ready) i1++;
            if (rst) esel = 1'b0;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst drain got %0d left exp 0", exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_release();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
